// File: rtl/controlled_reg.sv
// rtl/controlled_reg.sv - clock-enabled masked storage register with clear, valid flag and change pulse
// Optional registered even-parity output enabled by defining CONTROLLED_REG_PARITY_EN.
`timescale 1ns/1ps
module controlled_reg #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ce_in,
    input  logic [WIDTH-1:0] wmask_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] q_out,
    output logic             valid_out,
    output logic             changed_out
`ifdef CONTROLLED_REG_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;

    always_comb begin
        q_d       = q_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (clr_in) begin
            q_d       = RST_VAL;
            valid_d   = 1'b0;
            changed_d = (q_q != RST_VAL);
        end else if (ce_in) begin
            // Masked-off bits keep their stored value; a zero mask still marks the word written.
            q_d       = (q_q & ~wmask_in) | (d_in & wmask_in);
            valid_d   = 1'b1;
            changed_d = (q_d != q_q);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            q_q       <= RST_VAL;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign q_out       = q_q;
    assign valid_out   = valid_q;
    assign changed_out = changed_q;

`ifdef CONTROLLED_REG_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^q_d;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            parity_q <= ^RST_VAL;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_controlled_reg.sv
// tb/tb_controlled_reg.sv - scoreboard bench for controlled_reg (8-bit word and 1-bit cell)
`timescale 1ns/1ps
module tb_controlled_reg;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk;
    logic       rst_n;
    logic [7:0] d, wmask;
    logic       ce, clr;
    logic [7:0] q;
    logic       valid, changed;
`ifdef CONTROLLED_REG_PARITY_EN
    logic       parity;
    logic       parity1;
`endif

    logic       d1, wmask1, ce1, clr1;
    logic       q1, valid1, changed1;
    logic       reader_q;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       v;
        logic       c;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_q;
    logic       m_v;

    controlled_reg #(.WIDTH(8), .RST_VAL(RV)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .d_in       (d),
        .ce_in      (ce),
        .wmask_in   (wmask),
        .clr_in     (clr),
        .q_out      (q),
        .valid_out  (valid),
        .changed_out(changed)
`ifdef CONTROLLED_REG_PARITY_EN
        ,
        .parity_out (parity)
`endif
    );

    controlled_reg #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .d_in       (d1),
        .ce_in      (ce1),
        .wmask_in   (wmask1),
        .clr_in     (clr1),
        .q_out      (q1),
        .valid_out  (valid1),
        .changed_out(changed1)
`ifdef CONTROLLED_REG_PARITY_EN
        ,
        .parity_out (parity1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A downstream reader that samples the cell on the same edge as the write.
    always @(posedge clk) reader_q <= q1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and push the reference result for the coming edge.
    task automatic drive(input logic r, input logic cl, input logic c,
                         input logic [7:0] dv, input logic [7:0] mv);
        exp_t e;
        logic [7:0] nq;
        @(negedge clk);
        rst_n = r; clr = cl; ce = c; d = dv; wmask = mv;
        if (!r) begin
            e = '{q: RV, v: 1'b0, c: 1'b0};
        end else if (cl) begin
            e = '{q: RV, v: 1'b0, c: (m_q != RV)};
        end else if (c) begin
            nq = (m_q & ~mv) | (dv & mv);
            e = '{q: nq, v: 1'b1, c: (nq != m_q)};
        end else begin
            e = '{q: m_q, v: m_v, c: 1'b0};
        end
        m_q = e.q;
        m_v = e.v;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"}, q, e.q);
            check({tag, "_valid"}, {7'd0, valid}, {7'd0, e.v});
            check({tag, "_changed"}, {7'd0, changed}, {7'd0, e.c});
`ifdef CONTROLLED_REG_PARITY_EN
            check({tag, "_parity"}, {7'd0, parity}, {7'd0, ^e.q});
`endif
        end
    endtask

    task automatic step(input string tag, input logic r, input logic cl, input logic c,
                        input logic [7:0] dv, input logic [7:0] mv);
        drive(r, cl, c, dv, mv);
        tick(tag);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ce = 1'b0; d = 8'h00; wmask = 8'hFF;
        d1 = 1'b0; wmask1 = 1'b1; ce1 = 1'b0; clr1 = 1'b0;
        m_q = RV; m_v = 1'b0;

        step("reset0", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        step("reset1", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        check("reset_q_const", q, 8'h5A);
`ifdef CONTROLLED_REG_PARITY_EN
        check("reset_parity_const", {7'd0, parity}, 8'h00);
`endif

        step("write_c3", 1'b1, 1'b0, 1'b1, 8'hC3, 8'hFF);
        check("write_q_const", q, 8'hC3);
        check("write_changed_const", {7'd0, changed}, 8'h01);
        step("hold", 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
        check("hold_q_const", q, 8'hC3);

        step("mask_0f", 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F);
        check("mask_q_const", q, 8'hC0);
        step("mask_rep", 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F);
        check("mask_rep_changed_const", {7'd0, changed}, 8'h00);

        step("ce_hold_a", 1'b1, 1'b0, 1'b1, 8'h96, 8'hFF);
        step("ce_hold_b", 1'b1, 1'b0, 1'b1, 8'h96, 8'hFF);
        step("ce_hold_c", 1'b1, 1'b0, 1'b1, 8'h96, 8'hFF);
        step("ign_idle", 1'b1, 1'b0, 1'b0, 8'h11, 8'hFF);

        step("clr_ce", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        check("clr_q_const", q, 8'h5A);
        check("clr_valid_const", {7'd0, valid}, 8'h00);
        step("clr_again", 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);

        step("zero_mask", 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        check("zero_mask_valid_const", {7'd0, valid}, 8'h01);
        step("pre_rst_wr", 1'b1, 1'b0, 1'b1, 8'h3C, 8'hF0);
        step("rst_ce", 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
        check("rst_ce_q_const", q, 8'h5A);

        for (int i = 0; i < 8; i++) begin
            step("rand", 1'b1, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 8'($urandom), 8'($urandom));
        end

        // Single-bit cell: reader at the write edge sees old value, next edge sees new.
        step("cell_idle", 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
        @(negedge clk);
        ce1 = 1'b1; d1 = 1'b1;
        @(posedge clk);
        #1;
        check("cell_q", {7'd0, q1}, 8'h01);
        check("cell_reader_old", {7'd0, reader_q}, 8'h00);
        check("cell_changed", {7'd0, changed1}, 8'h01);
        @(negedge clk);
        ce1 = 1'b0; d1 = 1'b0;
        @(posedge clk);
        #1;
        check("cell_reader_new", {7'd0, reader_q}, 8'h01);
        check("cell_hold", {7'd0, q1}, 8'h01);
        check("cell_valid", {7'd0, valid1}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
